// File: rtl/onewire_handler.sv
// Standard-speed 1-Wire bus master driven by the command fabric.
// Executes reset, write, read and write-then-read commands, then streams read bytes to the upload port.
module onewire_handler #(
    parameter int CLK_FREQ = 25_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  cmd_type,
    input  logic [15:0] cmd_length,
    input  logic [7:0]  cmd_data,
    input  logic [15:0] cmd_data_index,
    input  logic        cmd_start,
    input  logic        cmd_data_valid,
    input  logic        cmd_done,
    output logic        cmd_ready,
    output logic        upload_active,
    output logic        upload_req,
    output logic [7:0]  upload_data,
    output logic [7:0]  upload_source,
    output logic        upload_valid,
    input  logic        upload_ready,
    inout  wire         onewire_io
);
    localparam int US = CLK_FREQ / 1_000_000;
    localparam int TW = $clog2(480 * US + 1);

    localparam logic [TW-1:0] T_RST_LOW = TW'(480 * US - 1);
    localparam logic [TW-1:0] T_PRES    = TW'(70 * US - 1);
    localparam logic [TW-1:0] T_RST_REC = TW'(410 * US - 1);
    localparam logic [TW-1:0] T_W1_LOW  = TW'(6 * US - 1);
    localparam logic [TW-1:0] T_W0_LOW  = TW'(60 * US - 1);
    localparam logic [TW-1:0] T_W1_REC  = TW'(64 * US - 2);
    localparam logic [TW-1:0] T_W0_REC  = TW'(10 * US - 2);
    localparam logic [TW-1:0] T_R_LOW   = TW'(6 * US - 1);
    localparam logic [TW-1:0] T_R_SAMP  = TW'(9 * US - 1);
    localparam logic [TW-1:0] T_R_REC   = TW'(55 * US - 2);

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_COLLECT = 4'd1,
        ST_RESET   = 4'd2,
        ST_WRITE   = 4'd3,
        ST_READ    = 4'd4,
        ST_UPLOAD  = 4'd5,
        ST_FINISH  = 4'd6
    } state_t;

    state_t        r_state;
    logic [1:0]    r_phase;
    logic [TW-1:0] r_timer;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic [7:0]    r_cmd;
    logic [4:0]    r_count;
    logic [4:0]    r_wr_ptr;
    logic [4:0]    r_wr_end;
    logic [7:0]    r_rd_left;
    logic          r_drive_low;
    logic          r_bus_meta;
    logic          r_bus_sync;
    logic          r_cmd_ready;
    logic          r_upload_active;
    logic          r_upload_valid;
    logic [7:0]    r_upload_data;
    logic [7:0]    r_buf [16];
    logic          ow_presence_detected;
    logic [3:0]    handler_state;

    logic          w_tick;
    logic          w_code_ok;
    logic [8:0]    w_wr_end_full;
    logic [4:0]    w_wr_end;
    logic          w_unused;

    assign onewire_io    = r_drive_low ? 1'b0 : 1'bz;
    assign handler_state = r_state;
    assign cmd_ready     = r_cmd_ready;
    assign upload_active = r_upload_active;
    assign upload_valid  = r_upload_valid;
    assign upload_req    = r_upload_valid;
    assign upload_data   = r_upload_data;
    assign upload_source = 8'h20;
    assign w_unused      = ^{cmd_length, cmd_data_index};

    assign w_tick        = (r_timer == '0);
    assign w_code_ok     = (cmd_type[7:2] == 6'b001000);
    // WRITE_READ data starts at byte 2; never run past the bytes actually received
    assign w_wr_end_full = 9'd2 + {1'b0, r_buf[0]};
    assign w_wr_end      = (w_wr_end_full > {4'b0, r_count}) ? r_count : w_wr_end_full[4:0];

    always_ff @(posedge clk) begin
        if (r_state == ST_COLLECT && cmd_data_valid && !r_count[4]) begin
            r_buf[r_count[3:0]] <= cmd_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bus_meta <= 1'b1;
            r_bus_sync <= 1'b1;
        end else begin
            r_bus_meta <= onewire_io;
            r_bus_sync <= r_bus_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state              <= ST_IDLE;
            r_phase              <= 2'd0;
            r_timer              <= '0;
            r_bit                <= 3'd0;
            r_shift              <= 8'd0;
            r_cmd                <= 8'd0;
            r_count              <= 5'd0;
            r_wr_ptr             <= 5'd0;
            r_wr_end             <= 5'd0;
            r_rd_left            <= 8'd0;
            r_drive_low          <= 1'b0;
            ow_presence_detected <= 1'b0;
            r_cmd_ready          <= 1'b1;
            r_upload_active      <= 1'b0;
            r_upload_valid       <= 1'b0;
            r_upload_data        <= 8'd0;
        end else begin
            if (!w_tick) r_timer <= r_timer - 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (cmd_start && w_code_ok) begin
                        r_cmd       <= cmd_type;
                        r_count     <= 5'd0;
                        r_cmd_ready <= 1'b0;
                        r_state     <= ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    if (cmd_data_valid && !r_count[4]) r_count <= r_count + 5'd1;
                    if (cmd_done) begin
                        r_phase <= 2'd0;
                        r_bit   <= 3'd0;
                        case (r_cmd)
                            8'h20: begin
                                r_drive_low <= 1'b1;
                                r_timer     <= T_RST_LOW;
                                r_state     <= ST_RESET;
                            end
                            8'h21: begin
                                r_wr_ptr  <= 5'd0;
                                r_wr_end  <= r_count;
                                r_rd_left <= 8'd0;
                                r_shift   <= r_buf[0];
                                r_state   <= (r_count == 5'd0) ? ST_FINISH : ST_WRITE;
                            end
                            8'h22: begin
                                r_rd_left <= r_buf[0];
                                if (r_buf[0] == 8'd0) begin
                                    r_state <= ST_FINISH;
                                end else begin
                                    r_upload_active <= 1'b1;
                                    r_state         <= ST_READ;
                                end
                            end
                            default: begin
                                r_wr_ptr  <= 5'd2;
                                r_wr_end  <= w_wr_end;
                                r_rd_left <= r_buf[1];
                                r_shift   <= r_buf[2];
                                if (w_wr_end > 5'd2) begin
                                    r_state <= ST_WRITE;
                                end else if (r_buf[1] != 8'd0) begin
                                    r_upload_active <= 1'b1;
                                    r_state         <= ST_READ;
                                end else begin
                                    r_state <= ST_FINISH;
                                end
                            end
                        endcase
                    end
                end
                ST_RESET: begin
                    if (w_tick) begin
                        case (r_phase)
                            2'd0: begin
                                r_drive_low <= 1'b0;
                                r_timer     <= T_PRES;
                                r_phase     <= 2'd1;
                            end
                            2'd1: begin
                                ow_presence_detected <= ~r_bus_sync;
                                r_timer              <= T_RST_REC;
                                r_phase              <= 2'd2;
                            end
                            default: r_state <= ST_FINISH;
                        endcase
                    end
                end
                ST_WRITE: begin
                    // Recovery loads are one short: the slot-start cycle completes the 70 us slot
                    case (r_phase)
                        2'd0: begin
                            r_drive_low <= 1'b1;
                            r_timer     <= r_shift[0] ? T_W1_LOW : T_W0_LOW;
                            r_phase     <= 2'd1;
                        end
                        2'd1: begin
                            if (w_tick) begin
                                r_drive_low <= 1'b0;
                                r_timer     <= r_shift[0] ? T_W1_REC : T_W0_REC;
                                r_phase     <= 2'd2;
                            end
                        end
                        default: begin
                            if (w_tick) begin
                                r_shift <= r_shift >> 1;
                                r_bit   <= r_bit + 3'd1;
                                r_phase <= 2'd0;
                                if (r_bit == 3'd7) begin
                                    if (r_wr_ptr + 5'd1 < r_wr_end) begin
                                        r_wr_ptr <= r_wr_ptr + 5'd1;
                                        r_shift  <= r_buf[r_wr_ptr[3:0] + 4'd1];
                                    end else if (r_rd_left != 8'd0) begin
                                        r_upload_active <= 1'b1;
                                        r_state         <= ST_READ;
                                    end else begin
                                        r_state <= ST_FINISH;
                                    end
                                end
                            end
                        end
                    endcase
                end
                ST_READ: begin
                    case (r_phase)
                        2'd0: begin
                            r_drive_low <= 1'b1;
                            r_timer     <= T_R_LOW;
                            r_phase     <= 2'd1;
                        end
                        2'd1: begin
                            if (w_tick) begin
                                r_drive_low <= 1'b0;
                                r_timer     <= T_R_SAMP;
                                r_phase     <= 2'd2;
                            end
                        end
                        2'd2: begin
                            if (w_tick) begin
                                r_shift <= {r_bus_sync, r_shift[7:1]};
                                r_timer <= T_R_REC;
                                r_phase <= 2'd3;
                            end
                        end
                        default: begin
                            if (w_tick) begin
                                r_bit   <= r_bit + 3'd1;
                                r_phase <= 2'd0;
                                if (r_bit == 3'd7) begin
                                    r_upload_data  <= r_shift;
                                    r_upload_valid <= 1'b1;
                                    r_state        <= ST_UPLOAD;
                                end
                            end
                        end
                    endcase
                end
                ST_UPLOAD: begin
                    if (upload_ready) begin
                        r_upload_valid <= 1'b0;
                        r_rd_left      <= r_rd_left - 8'd1;
                        r_state        <= (r_rd_left == 8'd1) ? ST_FINISH : ST_READ;
                    end
                end
                ST_FINISH: begin
                    r_upload_active <= 1'b0;
                    r_cmd_ready     <= 1'b1;
                    r_state         <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_onewire_handler.sv
// Bench for onewire_handler: a DS18B20-like device model on a pulled-up bus, a pulse monitor,
// and an upload scoreboard fed with the bytes each command must return.
module tb_onewire_handler;
    localparam int US = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  cmd_type = 8'd0;
    logic [15:0] cmd_length = 16'd0;
    logic [7:0]  cmd_data = 8'd0;
    logic [15:0] cmd_data_index = 16'd0;
    logic        cmd_start = 1'b0;
    logic        cmd_data_valid = 1'b0;
    logic        cmd_done = 1'b0;
    logic        upload_ready = 1'b1;
    logic        cmd_ready, upload_active, upload_req, upload_valid;
    logic [7:0]  upload_data, upload_source;
    wire         ow_bus;
    logic        dev_low = 1'b0;
    logic        dev_en = 1'b1;

    pullup (ow_bus);
    assign ow_bus = dev_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    onewire_handler #(.CLK_FREQ(2_000_000)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_type(cmd_type), .cmd_length(cmd_length),
        .cmd_data(cmd_data), .cmd_data_index(cmd_data_index), .cmd_start(cmd_start),
        .cmd_data_valid(cmd_data_valid), .cmd_done(cmd_done), .cmd_ready(cmd_ready),
        .upload_active(upload_active), .upload_req(upload_req), .upload_data(upload_data),
        .upload_source(upload_source), .upload_valid(upload_valid), .upload_ready(upload_ready),
        .onewire_io(ow_bus)
    );

    int vecs = 0;
    int errs = 0;
    int cyc = 0;
    int n_rx = 0;
    logic seen_active = 1'b0;
    logic [7:0] exp_q[$];
    logic [7:0] rx_log[$];
    logic [7:0] tx_q[$];
    int widths[$];
    int starts[$];
    logic [7:0] rom [8] = '{8'h28, 8'hFF, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hC3};
    logic [7:0] sp_conv [9] = '{8'h90, 8'h01, 8'h4B, 8'h46, 8'h7F, 8'hFF, 8'h0C, 8'h10, 8'h1C};
    logic [7:0] scratch [9] = '{8'h50, 8'h05, 8'h4B, 8'h46, 8'h7F, 8'hFF, 8'h0C, 8'h10, 8'h1C};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_near(input string name, input int act, input int exp);
        vecs++;
        if (act < exp - 1 || act > exp + 1) begin
            errs++;
            $display("FAIL %s: got %0d cycles, expected %0d +-1", name, act, exp);
        end
    endtask

    // Device model: decodes master slots from low time, answers reset with presence, serves ROM/scratchpad
    initial begin : dev_model
        logic m_now, m_prev, bit_v;
        logic [7:0] rx, txb;
        int m_cnt, hold, pres_wait, rx_n, tx_n, mode;
        m_prev = 0; m_cnt = 0; hold = 0; pres_wait = 0; rx_n = 0; tx_n = 0; mode = 0;
        rx = 0; txb = 0; bit_v = 1;
        forever begin
            @(negedge clk);
            m_now = (ow_bus === 1'b0) && !dev_low;
            if (!dev_en) begin
                dev_low = 0; hold = 0; pres_wait = 0; mode = 0; m_prev = m_now;
                continue;
            end
            if (hold > 0) begin
                hold--;
                if (hold == 0) dev_low = 0;
            end
            if (pres_wait > 0) begin
                pres_wait--;
                if (pres_wait == 0) begin dev_low = 1; hold = 120 * US; end
            end
            if (m_now && !m_prev) begin
                m_cnt = 0;
                if (mode == 3) begin
                    if (tx_n == 0 && tx_q.size() > 0) begin txb = tx_q.pop_front(); tx_n = 8; end
                    if (tx_n > 0) begin bit_v = txb[0]; txb = txb >> 1; tx_n--; end
                    else bit_v = 1;
                    if (!bit_v) begin dev_low = 1; hold = 30 * US; end
                end
            end
            if (m_now) m_cnt++;
            if (!m_now && m_prev) begin
                if (m_cnt > 400 * US) begin
                    pres_wait = 20 * US; mode = 1; rx_n = 0; tx_n = 0; tx_q.delete();
                end else if (mode == 1 || mode == 2) begin
                    rx = {(m_cnt < 15 * US), rx[7:1]};
                    rx_n++;
                    if (rx_n == 8) begin
                        rx_n = 0;
                        if (mode == 1) begin
                            if (rx == 8'h33) begin
                                for (int i = 0; i < 8; i++) tx_q.push_back(rom[i]);
                                mode = 3;
                            end else if (rx == 8'hCC) mode = 2;
                            else mode = 0;
                        end else begin
                            if (rx == 8'h44) begin
                                for (int i = 0; i < 9; i++) scratch[i] = sp_conv[i];
                                mode = 0;
                            end else if (rx == 8'hBE) begin
                                for (int i = 0; i < 9; i++) tx_q.push_back(scratch[i]);
                                mode = 3;
                            end else mode = 0;
                        end
                    end
                end
            end
            m_prev = m_now;
        end
    end

    // Records every master-driven low pulse: start cycle and width
    initial begin : bus_mon
        logic p, m;
        int w;
        p = 0; w = 0;
        forever begin
            @(posedge clk);
            cyc++;
            m = (ow_bus === 1'b0) && !dev_low;
            if (m && !p) begin starts.push_back(cyc); w = 0; end
            if (m) w++;
            if (!m && p) widths.push_back(w);
            p = m;
        end
    end

    initial begin : scoreboard
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("upload_source", upload_source, 8'h20);
                if (upload_active) seen_active = 1'b1;
                if (upload_valid) begin
                    check("exp_q_nonempty", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) check("upload_data", upload_data, exp_q[0]);
                    if (upload_ready) begin
                        if (exp_q.size() > 0) void'(exp_q.pop_front());
                        rx_log.push_back(upload_data);
                        n_rx++;
                        $display("upload byte %0d = %02h", n_rx, upload_data);
                    end
                end
            end
        end
    end

    task automatic send_cmd(input logic [7:0] t, input int n, input logic [7:0] b0,
                            input logic [7:0] b1, input logic [7:0] b2);
        logic [7:0] pl [3];
        pl[0] = b0; pl[1] = b1; pl[2] = b2;
        @(posedge clk); #1;
        cmd_type = t; cmd_length = 16'(n); cmd_start = 1;
        @(posedge clk); #1; cmd_start = 0;
        for (int i = 0; i < n; i++) begin
            cmd_data = pl[i]; cmd_data_index = 16'(i); cmd_data_valid = 1;
            @(posedge clk); #1; cmd_data_valid = 0;
        end
        cmd_done = 1;
        @(posedge clk); #1; cmd_done = 0;
        $display("command %02h issued with %0d payload bytes", t, n);
    endtask

    task automatic wait_idle(input int lim);
        int k;
        k = 0;
        while (!cmd_ready && k < lim) begin @(posedge clk); #1; k++; end
        check("idle_timeout", cmd_ready, 1);
    endtask

    task automatic clear_mon();
        widths.delete(); starts.delete();
    endtask

    initial begin : watchdog
        #20ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int t0, k, n0;
        logic [7:0] cc;
        repeat (5) @(posedge clk); #1;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_upload_valid", upload_valid, 0);
        check("rst_upload_req", upload_req, 0);
        check("rst_upload_active", upload_active, 0);
        check("rst_upload_data", upload_data, 8'h00);
        check("rst_upload_source", upload_source, 8'h20);
        check("rst_bus_released", ow_bus, 1);
        check("rst_state", dut.handler_state, 4'd0);
        check("rst_presence", dut.ow_presence_detected, 0);
        rst_n = 1;

        // Reset with device present, plus a stray cmd_start that must be ignored
        clear_mon(); seen_active = 0; t0 = cyc;
        send_cmd(8'h20, 0, 0, 0, 0);
        repeat (200) @(posedge clk); #1;
        cmd_type = 8'h21; cmd_start = 1; @(posedge clk); #1; cmd_start = 0;
        wait_idle(4000);
        check("reset_within_1ms", (cyc - t0) <= 1000 * US, 1);
        check("reset_pulse_count", widths.size(), 1);
        if (widths.size() > 0) check_near("reset_low_width", widths[0], 480 * US);
        check_near("reset_low_width_literal", (widths.size() > 0) ? widths[0] : 0, 960);
        check("presence_with_device", dut.ow_presence_detected, 1);
        check("reset_state_idle", dut.handler_state, 4'd0);
        check("reset_no_uploads", n_rx, 0);
        check("reset_no_active", seen_active, 0);

        // Reset with pull-up only
        dev_en = 0;
        send_cmd(8'h20, 0, 0, 0, 0);
        wait_idle(4000);
        check("presence_no_device", dut.ow_presence_detected, 0);
        dev_en = 1;

        // READ ROM via WRITE_READ
        send_cmd(8'h20, 0, 0, 0, 0);
        wait_idle(4000);
        for (int i = 0; i < 8; i++) exp_q.push_back(rom[i]);
        rx_log.delete(); n0 = n_rx; seen_active = 0;
        send_cmd(8'h23, 3, 8'd1, 8'd8, 8'h33);
        wait_idle(20000);
        check("rom_byte_count", n_rx - n0, 8);
        check("rom_exp_drained", exp_q.size(), 0);
        if (rx_log.size() > 0) check("rom_family_code", rx_log[0], 8'h28);
        check("rom_active_seen", seen_active, 1);
        check("rom_active_dropped", upload_active, 0);

        // Skip ROM + convert, then read scratchpad with a stalled consumer
        send_cmd(8'h20, 0, 0, 0, 0);
        wait_idle(4000);
        clear_mon();
        send_cmd(8'h21, 1, 8'hCC, 0, 0);
        wait_idle(4000);
        cc = 8'hCC;
        check("cc_slot_count", widths.size(), 8);
        for (int i = 0; i < 8 && i < widths.size(); i++) begin
            check_near("cc_low_width", widths[i], cc[i] ? 6 * US : 60 * US);
            if (i > 0) check_near("cc_slot_period", starts[i] - starts[i-1], 70 * US);
        end
        if (widths.size() > 2) check_near("cc_bit2_literal", widths[2], 12);
        send_cmd(8'h21, 1, 8'h44, 0, 0);
        wait_idle(4000);
        send_cmd(8'h20, 0, 0, 0, 0);
        wait_idle(4000);
        send_cmd(8'h21, 1, 8'hCC, 0, 0);
        wait_idle(4000);
        for (int i = 0; i < 9; i++) exp_q.push_back(sp_conv[i]);
        rx_log.delete(); n0 = n_rx;
        send_cmd(8'h23, 3, 8'd1, 8'd9, 8'hBE);
        k = 0;
        while (!upload_valid && k < 5000) begin @(posedge clk); #1; k++; end
        check("stall_valid_seen", upload_valid, 1);
        upload_ready = 0;
        repeat (100) @(posedge clk); #1;
        check("stall_valid_held", upload_valid, 1);
        check("stall_req_held", upload_req, 1);
        check("stall_data_stable", upload_data, 8'h90);
        check("stall_active", upload_active, 1);
        check("stall_no_transfer", n_rx - n0, 0);
        check("stall_bus_released", ow_bus, 1);
        upload_ready = 1;
        @(posedge clk); #1;
        check("stall_one_transfer", n_rx - n0, 1);
        check("stall_valid_dropped", upload_valid, 0);
        wait_idle(20000);
        check("sp_byte_count", n_rx - n0, 9);
        if (rx_log.size() > 1) begin
            check("sp_temp_lsb", rx_log[0], 8'h90);
            check("sp_temp_msb", rx_log[1], 8'h01);
        end
        check("sp_active_dropped", upload_active, 0);

        // Unknown command code is ignored
        send_cmd(8'h55, 0, 0, 0, 0);
        check("bad_cmd_ready", cmd_ready, 1);
        repeat (10) @(posedge clk); #1;
        check("bad_cmd_state", dut.handler_state, 4'd0);

        // Asynchronous reset in the middle of a READ
        exp_q.push_back(8'hFF); exp_q.push_back(8'hFF);
        n0 = n_rx;
        send_cmd(8'h22, 1, 8'd2, 0, 0);
        k = 0;
        while (n_rx == n0 && k < 3000) begin @(posedge clk); #1; k++; end
        check("midread_first_byte", n_rx - n0, 1);
        k = 0;
        while (ow_bus !== 1'b0 && k < 1000) begin @(posedge clk); #1; k++; end
        check("midread_bus_low", ow_bus, 0);
        #3 rst_n = 0;
        #1;
        check("midread_bus_released", ow_bus, 1);
        check("midread_state", dut.handler_state, 4'd0);
        check("midread_cmd_ready", cmd_ready, 1);
        check("midread_valid", upload_valid, 0);
        check("midread_active", upload_active, 0);
        check("midread_presence", dut.ow_presence_detected, 0);
        exp_q.delete();
        @(posedge clk); #1; rst_n = 1;
        repeat (5) @(posedge clk); #1;
        check("post_reset_idle", cmd_ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/onewire_handler.md
Name: onewire_handler

Overview:
- Command-bus-driven 1-Wire bus master (DS18B20-class sensors) on the shared command/upload fabric.
- Accepts reset, write, read and write-then-read commands, and generates standard-speed 1-Wire timing on an open-drain pin.
- Streams each read byte to the upload interface.

Parameters:
CLK_FREQ, 25_000_000, system clock in Hz; all microsecond timings are derived as CLK_FREQ/1_000_000 cycles per us.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
cmd_type  input  8  command code; sampled on cmd_start
cmd_length  input  16  payload length in bytes; informational
cmd_data  input  8  payload byte
cmd_data_index  input  16  payload byte index; ignored, bytes are stored sequentially
cmd_start  input  1  one-cycle command start pulse
cmd_data_valid  input  1  one-cycle pulse qualifying cmd_data
cmd_done  input  1  one-cycle end-of-payload pulse
cmd_ready  output  1  high only in IDLE
upload_active  output  1  high from the first read slot until the last read byte is accepted
upload_req  output  1  high while a read byte is waiting for acceptance
upload_data  output  8  read byte
upload_source  output  8  constant 8'h20
upload_valid  output  1  read byte valid
upload_ready  input  1  downstream accept
onewire_io  inout  1  open-drain bus (drives 0 or Z); external pull-up

Behaviour:
- Reset values: cmd_ready=1; all upload_* outputs 0 except upload_source=8'h20; bus released (Z); handler_state=0; ow_presence_detected=0.
- Bus input: synchronized through a 2-FF synchronizer before sampling.
- Commands: 0x20 RESET; 0x21 WRITE (payload = bytes to write); 0x22 READ (payload byte0 = read_len); 0x23 WRITE_READ (byte0 = write_len, byte1 = read_len, then write_len data bytes).
- Other cmd_type values: ignored, handler stays in IDLE.
- Payload buffer: 16 bytes, filled in arrival order by an internal counter reset on cmd_start; bytes beyond 16 are dropped.
- 4-bit handler_state: 0 IDLE, 1 COLLECT, 2 RESET, 3 WRITE, 4 READ, 5 UPLOAD, 6 FINISH.
- IDLE -> COLLECT on cmd_start with a valid code.
- COLLECT -> (on cmd_done) RESET for 0x20, WRITE for 0x21/0x23, READ for 0x22.
- 0x23 with write_len=0 goes straight to READ; read_len=0 finishes after the writes.
- RESET slot: drive low 480 us, release. Sample at +70 us: low -> ow_presence_detected=1, else 0. Wait a further 410 us, then FINISH.
- WRITE bit slots, LSB first:
  - '1' = low 6 us then release 64 us.
  - '0' = low 60 us then release 10 us.
- After all write bytes: READ if read_len>0, else FINISH.
- READ bit slot: low 6 us, release, sample at +9 us after release, then idle 55 us. Bits assembled LSB first.
- After 8 bits -> UPLOAD: upload_data=byte, upload_valid=upload_req=1, held until upload_ready is high on a clock edge; exactly one byte transfers per valid&&ready edge.
- After the transfer: valid/req drop next cycle; back to READ if bytes remain, else FINISH.
- upload_ready low stalls in UPLOAD indefinitely with the bus released.
- FINISH: deassert upload_active, go to IDLE (1 cycle).
- cmd_start outside IDLE is ignored.
- Asynchronous reset mid-operation: bus released immediately, all state to reset values.
- ow_presence_detected: readable internal register, holding its value between commands.

Test Plan:
- RESET (0x20, length 0) with DS18B20 model on bus -> ~480 us low pulse, ow_presence_detected=1, handler_state back to 0 within 1 ms; no upload bytes.
- RESET with no device (pull-up only) -> ow_presence_detected=0.
- WRITE_READ 0x23, payload {1,8,0x33} after reset -> 8 upload bytes, byte0=0x28 (family code); upload_active deasserts after byte 7.
- Reset, WRITE 0xCC, WRITE 0x44, reset, WRITE 0xCC, then WRITE_READ {1,9,0xBE} -> 9 bytes, byte0=0x90, byte1=0x01 (raw 0x0190 = 25.0 C).
- WRITE 0xCC -> 8 slots LSB first; the four '0' bits have ~60 us low time, the four '1' bits ~6 us low time; each slot 70 us.
- upload_ready held low 100 cycles during a read -> upload_valid stays high with stable data; the byte is counted once on release; rst_n asserted mid-read -> bus Z and handler_state=0.
